// File: rtl/mult_div_unit_pkg.sv
// Shared constants for the iterative multiply/divide unit: operand width,
// operation encodings and FSM state names.
package mult_div_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  // Counter value seen on the edge that performs the final iteration
  localparam logic [5:0] LAST_ITER = 6'(XLEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/mdu_iter_step.sv
// One combinational iteration of the shared datapath: shift-add for
// multiply, restoring shift-subtract for divide, on a {hi,lo} register pair.
module mdu_iter_step #(
  parameter int XLEN = 32
) (
  input  logic            i_isDiv,
  input  logic [XLEN-1:0] i_hi,
  input  logic [XLEN-1:0] i_lo,
  input  logic [XLEN-1:0] i_operand,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo
);

  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_shifted;
  logic            w_fits;
  logic [XLEN-1:0] w_diff;

  assign w_sum     = i_lo[0] ? ({1'b0, i_hi} + {1'b0, i_operand}) : {1'b0, i_hi};
  assign w_shifted = {i_hi, i_lo[XLEN-1]};
  // The shifted remainder can reach XLEN+1 bits; its top bit alone guarantees the subtract fits
  assign w_fits    = w_shifted[XLEN] | (w_shifted[XLEN-1:0] >= i_operand);
  assign w_diff    = w_shifted[XLEN-1:0] - i_operand;

  always_comb begin
    o_hi = w_sum[XLEN:1];
    o_lo = {w_sum[0], i_lo[XLEN-1:1]};
    if (i_isDiv) begin
      o_hi = w_fits ? w_diff : w_shifted[XLEN-1:0];
      o_lo = {i_lo[XLEN-2:0], w_fits};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative 32-bit MULTU/MULT/DIVU/DIV unit with a fixed 34-cycle latency;
// operands are latched as magnitudes and the sign is fixed up afterwards.
module mult_div_unit #(
  parameter int XLEN = mult_div_unit_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            div_by_zero
);

  import mult_div_unit_pkg::*;

  state_e            r_state;
  state_e            w_nextState;
  logic [5:0]        r_count;
  logic              r_isDiv;
  logic              r_negResult;
  logic              r_negRem;
  logic [XLEN-1:0]   r_opA;
  logic [XLEN-1:0]   r_operand;
  logic [XLEN-1:0]   r_accHi;
  logic [XLEN-1:0]   r_accLo;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic              r_divByZero;

  logic              w_isDivOp;
  logic              w_isSigned;
  logic              w_signA;
  logic              w_signB;
  logic [XLEN-1:0]   w_absA;
  logic [XLEN-1:0]   w_absB;
  logic [XLEN-1:0]   w_stepHi;
  logic [XLEN-1:0]   w_stepLo;
  logic              w_bZero;
  logic [2*XLEN-1:0] w_product;
  logic [2*XLEN-1:0] w_negProduct;
  logic [XLEN-1:0]   w_fixHi;
  logic [XLEN-1:0]   w_fixLo;

  assign w_isDivOp  = (op == OP_DIVU) || (op == OP_DIV);
  assign w_isSigned = (op == OP_MULT) || (op == OP_DIV);
  assign w_signA    = w_isSigned & operand_a[XLEN-1];
  assign w_signB    = w_isSigned & operand_b[XLEN-1];
  assign w_absA     = w_signA ? -operand_a : operand_a;
  assign w_absB     = w_signB ? -operand_b : operand_b;

  mdu_iter_step #(.XLEN(XLEN)) u_step (
    .i_isDiv   (r_isDiv),
    .i_hi      (r_accHi),
    .i_lo      (r_accLo),
    .i_operand (r_operand),
    .o_hi      (w_stepHi),
    .o_lo      (w_stepLo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE: if (start) w_nextState = CALC;
      CALC: if (r_count == LAST_ITER) w_nextState = FIX;
      FIX:  w_nextState = DONE;
      DONE: w_nextState = IDLE;
    endcase
  end

  assign w_bZero      = (r_operand == '0);
  assign w_product    = {r_accHi, r_accLo};
  assign w_negProduct = -w_product;

  // Divide by zero bypasses sign fix-up so hi returns the dividend exactly as given
  always_comb begin
    w_fixHi = r_accHi;
    w_fixLo = r_accLo;
    if (!r_isDiv) begin
      if (r_negResult) {w_fixHi, w_fixLo} = w_negProduct;
    end else if (w_bZero) begin
      w_fixHi = r_opA;
      w_fixLo = '1;
    end else begin
      if (r_negResult) w_fixLo = -r_accLo;
      if (r_negRem)    w_fixHi = -r_accHi;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count     <= '0;
      r_isDiv     <= 1'b0;
      r_negResult <= 1'b0;
      r_negRem    <= 1'b0;
      r_opA       <= '0;
      r_operand   <= '0;
      r_accHi     <= '0;
      r_accLo     <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_divByZero <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_count     <= '0;
            r_isDiv     <= w_isDivOp;
            r_negResult <= w_signA ^ w_signB;
            r_negRem    <= w_signA;
            r_opA       <= operand_a;
            r_operand   <= w_absB;
            r_accHi     <= '0;
            r_accLo     <= w_absA;
            r_divByZero <= 1'b0;
          end
        end
        CALC: begin
          r_accHi <= w_stepHi;
          r_accLo <= w_stepLo;
          r_count <= r_count + 6'd1;
        end
        FIX: begin
          r_hi        <= w_fixHi;
          r_lo        <= w_fixLo;
          r_divByZero <= r_isDiv & w_bZero;
        end
        DONE: ;
      endcase
    end
  end

  assign busy        = (r_state != IDLE);
  assign done        = (r_state == DONE);
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign div_by_zero = r_divByZero;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: a reference model queues expected
// results at accept, and a monitor pops and compares them on each done pulse.
module tb_mult_div_unit;

  import mult_div_unit_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic            div_by_zero;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          acceptCycle;
  } expect_t;

  expect_t sbQ[$];
  expect_t lastExp;
  int      testCount = 0;
  int      failCount = 0;
  int      cycle = 0;
  logic    prevDone = 1'b0;

  mult_div_unit #(.XLEN(XLEN)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic expect_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    expect_t     e;
    logic [63:0] p;
    int          sa;
    int          sb;
    e.hi = '0; e.lo = '0; e.dbz = 1'b0; e.acceptCycle = 0;
    sa = a;
    sb = b;
    case (o)
      OP_MULTU: begin
        p = {32'd0, a} * {32'd0, b};
        {e.hi, e.lo} = p;
      end
      OP_MULT: begin
        p = longint'(sa) * longint'(sb);
        {e.hi, e.lo} = p;
      end
      OP_DIVU: begin
        if (b == 0) begin
          e.lo = 32'hFFFF_FFFF; e.hi = a; e.dbz = 1'b1;
        end else begin
          e.lo = a / b; e.hi = a % b;
        end
      end
      default: begin
        if (b == 0) begin
          e.lo = 32'hFFFF_FFFF; e.hi = a; e.dbz = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          e.lo = 32'h8000_0000; e.hi = '0;
        end else begin
          e.lo = sa / sb; e.hi = sa % sb;
        end
      end
    endcase
    return e;
  endfunction

  // Drives one accepted request, then scrambles operands to prove they were latched
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    expect_t e;
    @(negedge clk);
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    @(negedge clk);
    start = 1'b0; op = 2'($urandom_range(0, 3)); operand_a = $urandom; operand_b = $urandom;
    e = model(o, a, b);
    e.acceptCycle = cycle;
    sbQ.push_back(e);
    lastExp = e;
    checkOutput("busyAfterAccept", 64'(busy), 64'd1);
    checkOutput("dbzClearedAtAccept", 64'(div_by_zero), 64'd0);
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while ((sbQ.size() != 0 || busy) && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    checkOutput("drainTimeout", 64'(sbQ.size() != 0 || busy), 64'd0);
  endtask

  task automatic pulseIgnoredStart(input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = OP_MULTU; operand_a = a; operand_b = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  always @(negedge clk) begin
    expect_t e;
    if (rst) begin
      prevDone <= 1'b0;
    end else begin
      if (done) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpectedDone", 64'(done), 64'd0);
        end else begin
          e = sbQ.pop_front();
          checkOutput("lo", 64'(lo), 64'(e.lo));
          checkOutput("hi", 64'(hi), 64'(e.hi));
          checkOutput("divByZero", 64'(div_by_zero), 64'(e.dbz));
          checkOutput("latency", 64'(cycle - e.acceptCycle), 64'd33);
          checkOutput("busyInDone", 64'(busy), 64'd1);
        end
        if (prevDone) checkOutput("donePulseWidth", 64'(prevDone && done), 64'd0);
      end
      prevDone <= done;
    end
  end

  logic [1:0]  vecOp [12];
  logic [31:0] vecA  [12];
  logic [31:0] vecB  [12];

  initial begin
    int n;
    vecOp = '{OP_MULTU, OP_MULT, OP_DIVU, OP_DIV, OP_DIV, OP_DIVU, OP_MULTU,
              OP_DIV, OP_DIV, OP_DIV, OP_MULT, OP_MULT};
    vecA  = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd100, 32'hFFFF_FFF9, 32'h8000_0000, 32'd5, 32'd2,
              32'hFFFF_FFF0, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'h8000_0000};
    vecB  = '{32'hFFFF_FFFF, 32'd7, 32'd7, 32'd2, 32'hFFFF_FFFF, 32'd0, 32'd3,
              32'd0, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h8000_0000};

    rst = 1'b1; start = 1'b0; op = '0; operand_a = '0; operand_b = '0;
    #3;
    checkOutput("resetBusy", 64'(busy), 64'd0);
    checkOutput("resetDone", 64'(done), 64'd0);
    checkOutput("resetHi", 64'(hi), 64'd0);
    checkOutput("resetLo", 64'(lo), 64'd0);
    checkOutput("resetDbz", 64'(div_by_zero), 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    foreach (vecOp[i]) begin
      applyStimulus(vecOp[i], vecA[i], vecB[i]);
      waitIdle(60);
    end

    for (int i = 0; i < 10; i++) begin
      applyStimulus(2'($urandom_range(0, 3)), $urandom, (i % 4 == 3) ? 32'd0 : $urandom);
      waitIdle(60);
    end

    repeat (5) @(negedge clk);
    checkOutput("holdLo", 64'(lo), 64'(lastExp.lo));
    checkOutput("holdHi", 64'(hi), 64'(lastExp.hi));

    applyStimulus(OP_DIVU, 32'd1000, 32'd7);
    repeat (5) @(negedge clk);
    pulseIgnoredStart(32'hFFFF_FFFF, 32'h1234_5678);
    n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reachDone", 64'(done), 64'd1);
    pulseIgnoredStart(32'h0BAD_F00D, 32'h0000_0003);
    waitIdle(60);
    repeat (3) @(negedge clk);
    checkOutput("startInDoneIgnored", 64'(busy), 64'd0);

    applyStimulus(OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    sbQ.delete();
    #1;
    checkOutput("midResetBusy", 64'(busy), 64'd0);
    checkOutput("midResetDone", 64'(done), 64'd0);
    checkOutput("midResetHi", 64'(hi), 64'd0);
    checkOutput("midResetLo", 64'(lo), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    checkOutput("noDoneAfterAbort", 64'(busy), 64'd0);

    applyStimulus(OP_DIVU, 32'd9, 32'd3);
    waitIdle(60);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter XLEN, default 32, operand and result width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 operand_a  input  32  multiplicand / dividend, driven from register-file read_data1.
REQ-007 operand_b  input  32  multiplier / divisor, driven from register-file read_data2.
REQ-008 busy  output  1  high whenever the state is not IDLE.
REQ-009 done  output  1  single-cycle pulse; hi/lo hold a new valid result.
REQ-010 hi  output  32  product[63:32] or remainder.
REQ-011 lo  output  32  product[31:0] or quotient.
REQ-012 div_by_zero  output  1  qualifies done; high when a divide had operand_b == 0.

Function
REQ-013 FSM states SHALL be IDLE, CALC, FIX, DONE.
REQ-014 IDLE->CALC on a rising edge with start=1: latch op and operands, clear the 6-bit iteration counter; signed ops latch absolute values plus result sign flags.
REQ-015 CALC SHALL perform one iteration per edge: shift-add for multiply, restoring shift-subtract for divide; 32 iterations, then CALC->FIX.
REQ-016 FIX SHALL apply sign correction and write hi/lo on its exit edge, then go to DONE.
REQ-017 Signed multiply: 64-bit two's-complement negation when the operand signs differ.
REQ-018 Signed divide: quotient negated when the signs differ; remainder takes the sign of the dividend (truncating division).
REQ-019 Latency SHALL be fixed for every op, including special cases: done is high in the 34th cycle after the accept edge (accept edge E0, done high between E33 and E34).
REQ-020 DONE SHALL assert done for exactly one cycle, then return to IDLE; busy=1 in CALC, FIX and DONE.
REQ-021 start while busy=1, including the DONE cycle, SHALL be ignored with no queuing; operand changes after acceptance SHALL have no effect.
REQ-022 Divide by zero (DIVU or DIV): lo=0xFFFFFFFF, hi=operand_a as latched, div_by_zero=1 alongside done.
REQ-023 DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0, div_by_zero=0.
REQ-024 hi/lo SHALL hold their last result until the next FIX exit edge or reset.
REQ-025 div_by_zero SHALL hold its value until the next accept edge, which clears it.

Reset
REQ-026 rst=1 SHALL immediately force state IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0, counter=0, independent of clk.
REQ-027 rst during CALC/FIX/DONE SHALL abort the operation with no done pulse; the first start after rst deasserts SHALL behave normally.

Structure
REQ-028 A shared package SHALL hold XLEN, the op encodings (OP_MULTU/OP_MULT/OP_DIVU/OP_DIV) and the FSM state enum, for use by the decoder and the bench.
REQ-029 One sub-module, mdu_iter_step, SHALL hold the combinational single-iteration add/subtract-shift datapath; the FSM, counter and sign handling stay in mult_div_unit.
REQ-030 Implementation target is 120-400 lines of RTL, with no multiply or divide operators.

Verification
REQ-031 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done high exactly in cycle E33-E34 and for one cycle only.
REQ-032 MULT 0xFFFFFFFD (-3) x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIVU 100/7 -> lo=14, hi=2.
REQ-033 DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
REQ-034 DIVU 5/0 -> lo=0xFFFFFFFF, hi=5, div_by_zero=1 with done at the normal latency; the next MULTU 2x3 clears div_by_zero at accept and ends with lo=6.
REQ-035 start re-pulsed during CALC and during DONE with new operands -> ignored; result matches the first operands only.
REQ-036 rst asserted mid-clock at CALC iteration 10 -> busy=0 and hi=lo=0 before the next edge, no done pulse; the following DIVU 9/3 -> lo=3, hi=0.
